// File: rtl/result_fwd_pipe.sv
// Result staging/forwarding pipe: units inject at fixed stages, entries drain to a registered
// writeback port. Optional collision counter output enabled by RESULT_FWD_PIPE_STATS_EN.
module result_fwd_pipe #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int DEPTH = 7,
  parameter int NUM_UNITS = 3,
  parameter logic [NUM_UNITS*4-1:0] INJ_STAGES = {4'd1, 4'd6, 4'd4},
  parameter int NUM_LOOKUP = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_UNITS-1:0]         unit_valid,
  input  logic [NUM_UNITS*DATA_W-1:0]  unit_data,
  input  logic [NUM_UNITS*ADDR_W-1:0]  unit_addr,
  input  logic [DEPTH-1:0]             kill_mask,
  input  logic [NUM_LOOKUP*ADDR_W-1:0] lk_addr,
  output logic [NUM_LOOKUP-1:0]        lk_hit,
  output logic [NUM_LOOKUP*DATA_W-1:0] lk_data,
  output logic [DEPTH*DATA_W-1:0]      fw_data,
  output logic [DEPTH*ADDR_W-1:0]      fw_addr,
  output logic [DEPTH-1:0]             fw_write,
  output logic [DATA_W-1:0]            wb_data,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic                         wb_write,
  output logic                         coll,
  output logic [ADDR_W-1:0]            coll_addr
`ifdef RESULT_FWD_PIPE_STATS_EN
  ,
  output logic [15:0]                  coll_count
`endif
);

  logic [DEPTH-1:1] w_disp;
  logic             w_coll_any;
  logic [ADDR_W-1:0] w_coll_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [ADDR_W-1:0] r_wb_addr;
  logic              r_wb_write;
  logic              r_coll;
  logic [ADDR_W-1:0] r_coll_addr;
  logic              w_unused;

  // Stage 0 has no register; it only feeds the shift into stage 1.
  assign w_unused               = kill_mask[0];
  assign fw_data[DATA_W-1:0]    = '0;
  assign fw_addr[ADDR_W-1:0]    = '0;
  assign fw_write[0]            = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      logic              w_inj;
      logic [DATA_W-1:0] w_next_data;
      logic [ADDR_W-1:0] w_next_addr;
      logic [DATA_W-1:0] r_data;
      logic [ADDR_W-1:0] r_addr;
      logic              r_write;

      // Descending scan so the lowest unit index wins an (illegal) shared stage.
      always_comb begin
        w_inj       = 1'b0;
        w_next_data = fw_data[(gi-1)*DATA_W +: DATA_W];
        w_next_addr = fw_addr[(gi-1)*ADDR_W +: ADDR_W];
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
          if (unit_valid[u] && (INJ_STAGES[u*4 +: 4] == 4'(gi))) begin
            w_inj       = 1'b1;
            w_next_data = unit_data[u*DATA_W +: DATA_W];
            w_next_addr = unit_addr[u*ADDR_W +: ADDR_W];
          end
        end
      end

      assign w_disp[gi] = w_inj & fw_write[gi-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_data  <= '0;
          r_addr  <= '0;
          r_write <= 1'b0;
        end else begin
          r_data  <= w_next_data;
          r_addr  <= w_next_addr;
          r_write <= (w_inj | fw_write[gi-1]) & ~kill_mask[gi];
        end
      end

      assign fw_data[gi*DATA_W +: DATA_W] = r_data;
      assign fw_addr[gi*ADDR_W +: ADDR_W] = r_addr;
      assign fw_write[gi]                 = r_write;
    end
  endgenerate

  always_comb begin
    w_coll_any  = |w_disp;
    w_coll_addr = '0;
    for (int s = DEPTH - 1; s >= 1; s--) begin
      if (w_disp[s]) begin
        w_coll_addr = fw_addr[(s-1)*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data   <= '0;
      r_wb_addr   <= '0;
      r_wb_write  <= 1'b0;
      r_coll      <= 1'b0;
      r_coll_addr <= '0;
    end else begin
      r_wb_data  <= fw_data[(DEPTH-1)*DATA_W +: DATA_W];
      r_wb_addr  <= fw_addr[(DEPTH-1)*ADDR_W +: ADDR_W];
      r_wb_write <= fw_write[DEPTH-1];
      r_coll     <= w_coll_any;
      if (w_coll_any) begin
        r_coll_addr <= w_coll_addr;
      end
    end
  end

  assign wb_data   = r_wb_data;
  assign wb_addr   = r_wb_addr;
  assign wb_write  = r_wb_write;
  assign coll      = r_coll;
  assign coll_addr = r_coll_addr;

  // Writeback is checked first, then stages oldest-to-youngest, so the youngest match wins.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int k = 0; k < NUM_LOOKUP; k++) begin
      if (r_wb_write && (r_wb_addr == lk_addr[k*ADDR_W +: ADDR_W])) begin
        lk_hit[k]                   = 1'b1;
        lk_data[k*DATA_W +: DATA_W] = r_wb_data;
      end
      for (int s = DEPTH - 1; s >= 1; s--) begin
        if (fw_write[s] && (fw_addr[s*ADDR_W +: ADDR_W] == lk_addr[k*ADDR_W +: ADDR_W])) begin
          lk_hit[k]                   = 1'b1;
          lk_data[k*DATA_W +: DATA_W] = fw_data[s*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef RESULT_FWD_PIPE_STATS_EN
  logic [15:0] r_coll_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll_count <= '0;
    end else if (w_coll_any && (r_coll_count != 16'hFFFF)) begin
      r_coll_count <= r_coll_count + 16'd1;
    end
  end

  assign coll_count = r_coll_count;
`endif

endmodule
